sram_arbiter: RTL and testbench

Three-port scheduler for the single external SRAM: the VGA display reader, the decoder datapath and the UART image loader. Fixed top priority to VGA; starvation-bounded sharing between decoder and UART. Drives the registered SRAM address, write-data and write-enable, and routes returned read data to the issuing port via a latency-matched tag pipeline. Sits in the top level between the SRAM controller and all SRAM masters.

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/sram_tag_pipe.sv | 38 +++
 rtl/sram_arbiter.sv | 109 ++++++++++
 tb/tb_sram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: requester identifiers and the read-return tag.
package sram_arbiter_pkg;

    localparam int unsigned NumPorts = 3;

    typedef enum logic [1:0] {
        PORT_VGA  = 2'd0,
        PORT_DEC  = 2'd1,
        PORT_UART = 2'd2
    } sram_port_e;

    typedef struct packed {
        logic       valid;
        sram_port_e port;
    } arb_tag_t;

endpackage

// File: rtl/sram_tag_pipe.sv
// Latency-matched shift register of read tags; the last stage steers rvalid to the issuing port.
module sram_tag_pipe
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  arb_tag_t            tag_i,
    output logic [NumPorts-1:0] rvalid_o
);

    arb_tag_t stage_q [Depth];
    arb_tag_t last;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign last = stage_q[Depth-1];

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NumPorts; k++) begin
            rvalid_o[k] = last.valid && (last.port == sram_port_e'(2'(k)));
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port SRAM scheduler: VGA has absolute priority, decoder beats UART except when the
// UART has been denied long enough to force a grant. Read data is routed back by tag.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [NumPorts-1:0] req_i,
    input  logic [NumPorts-1:0] we_i,
    input  logic [17:0]         addr_i [NumPorts],
    input  logic [15:0]         wdata_i [NumPorts],
    output logic [NumPorts-1:0] gnt_o,
    output logic [NumPorts-1:0] rvalid_o,
    output logic [15:0]         rdata_o,
    output logic [17:0]         SRAM_address,
    output logic [15:0]         SRAM_write_data,
    output logic                SRAM_we_n,
    input  logic [15:0]         SRAM_read_data,
    output logic                uart_starved_o
);

    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        force_uart;
    logic        any_gnt;
    sram_port_e  winner;
    arb_tag_t    issue_tag;

    assign force_uart = (wait_cnt_q == 4'(WAIT_MAX));

    always_comb begin
        gnt_o  = '0;
        winner = PORT_VGA;
        if (req_i[PORT_VGA]) begin
            gnt_o[PORT_VGA] = 1'b1;
            winner          = PORT_VGA;
        end else if (force_uart && req_i[PORT_UART]) begin
            gnt_o[PORT_UART] = 1'b1;
            winner           = PORT_UART;
        end else if (req_i[PORT_DEC]) begin
            gnt_o[PORT_DEC] = 1'b1;
            winner          = PORT_DEC;
        end else if (req_i[PORT_UART]) begin
            gnt_o[PORT_UART] = 1'b1;
            winner           = PORT_UART;
        end
    end

    assign any_gnt = |gnt_o;

    always_comb begin
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = 1'b1;
        if (any_gnt) begin
            sram_addr_d  = addr_i[winner];
            sram_wdata_d = wdata_i[winner];
            sram_we_n_d  = ~we_i[winner];
        end
    end

    // VGA cycles freeze the count: they neither add to nor relieve UART starvation.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_i[PORT_UART] || gnt_o[PORT_UART]) begin
            wait_cnt_d = '0;
        end else if (!req_i[PORT_VGA] && !force_uart) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            wait_cnt_q   <= '0;
        end else begin
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign issue_tag.valid = any_gnt & ~we_i[winner];
    assign issue_tag.port  = winner;

    sram_tag_pipe #(
        .Depth(READ_LAT + 1)
    ) u_tag_pipe (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .tag_i   (issue_tag),
        .rvalid_o(rvalid_o)
    );

    assign SRAM_address    = sram_addr_q;
    assign SRAM_write_data = sram_wdata_q;
    assign SRAM_we_n       = sram_we_n_q;
    assign rdata_o         = SRAM_read_data;
    assign uart_starved_o  = force_uart;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a two-cycle-latency write-through SRAM model.
module tb_sram_arbiter;

    logic        Clock;
    logic        Resetn;
    logic [2:0]  req, we, gnt, rvalid;
    logic [17:0] addr [3];
    logic [15:0] wdata [3];
    logic [15:0] rdata;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        uart_starved;

    int n_chk;
    int n_fail;

    sram_arbiter dut (
        .Clock          (Clock),
        .Resetn         (Resetn),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data),
        .uart_starved_o (uart_starved)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // SRAM model: address seen on the pins in cycle N returns data in cycle N+2.
    logic [15:0] mem [logic [17:0]];
    logic [17:0] a1;
    logic [15:0] rd_q;

    function automatic logic [15:0] lookup(input logic [17:0] a);
        return mem.exists(a) ? mem[a] : 16'hDEAD;
    endfunction

    always @(posedge Clock) begin
        if (!SRAM_we_n) mem[SRAM_address] = SRAM_write_data;
        a1   <= SRAM_address;
        rd_q <= lookup(a1);
    end
    assign SRAM_read_data = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge Clock);
        #1;
    endtask

    task automatic samp();
        @(negedge Clock);
    endtask

    task automatic idle();
        req = '0;
        we  = '0;
    endtask

    task automatic drive(input int p, input logic w, input logic [17:0] a, input logic [15:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) next();
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
    } vec_t;

    vec_t vecs [8];

    logic [2:0]  exp_rv [4];
    logic [15:0] exp_rd [4];
    int          iss_port [4];
    logic [17:0] iss_addr [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mem[18'h00100] = 16'hBEEF;
        mem[18'h00010] = 16'h1111;
        mem[18'h00020] = 16'h2222;
        mem[18'h00030] = 16'h3333;
        mem[18'h00040] = 16'h4444;

        vecs[0] = '{3'b000, 3'b000};
        vecs[1] = '{3'b001, 3'b001};
        vecs[2] = '{3'b010, 3'b010};
        vecs[3] = '{3'b100, 3'b100};
        vecs[4] = '{3'b011, 3'b001};
        vecs[5] = '{3'b101, 3'b001};
        vecs[6] = '{3'b110, 3'b010};
        vecs[7] = '{3'b111, 3'b001};

        Resetn = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        #2;

        // Combinational priority, exercised while reset holds the starvation count at zero.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            #1;
            chk($sformatf("gnt_table[%0d]", i), gnt, vecs[i].gnt);
        end
        idle();
        #1;
        chk("rst_addr", SRAM_address, 18'h0);
        chk("rst_wdata", SRAM_write_data, 16'h0);
        chk("rst_we_n", SRAM_we_n, 1'b1);
        chk("rst_rvalid", rvalid, 3'b000);
        chk("rst_starved", uart_starved, 1'b0);
        next();
        Resetn = 1'b1;
        drain(2);

        // Single decoder read.
        next(); drive(1, 1'b0, 18'h00100, 16'h0); samp();
        chk("rd1_gnt", gnt, 3'b010);
        next(); idle(); samp();
        chk("rd1_addr", SRAM_address, 18'h00100);
        chk("rd1_we_n", SRAM_we_n, 1'b1);
        chk("rd1_rv_c1", rvalid, 3'b000);
        next(); samp();
        chk("rd1_rv_c2", rvalid, 3'b000);
        next(); samp();
        chk("rd1_rv_c3", rvalid, 3'b010);
        chk("rd1_rdata", rdata, 16'hBEEF);
        next(); samp();
        chk("rd1_rv_c4", rvalid, 3'b000);
        drain(3);

        // VGA holds the bus for five cycles against the decoder.
        next(); drive(0, 1'b0, 18'h00010, 16'h0); drive(1, 1'b0, 18'h00020, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            samp();
            chk($sformatf("vga_pri[%0d]", i), gnt, 3'b001);
        end
        next(); req[0] = 1'b0; samp();
        chk("vga_pri_dec", gnt, 3'b010);
        drain(5);

        // Decoder streams; UART is forced in on its 9th request cycle.
        next(); drive(1, 1'b0, 18'h00020, 16'h0); drive(2, 1'b0, 18'h00030, 16'h0);
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) next();
            samp();
            chk($sformatf("starve_gnt[%0d]", i), gnt, 3'b010);
            chk($sformatf("starve_flag[%0d]", i), uart_starved, 1'b0);
        end
        next(); samp();
        chk("starve_force_flag", uart_starved, 1'b1);
        chk("starve_force_gnt", gnt, 3'b100);
        next(); samp();
        chk("starve_resume_gnt", gnt, 3'b010);
        chk("starve_resume_flag", uart_starved, 1'b0);
        drain(5);

        // Forced UART still yields to VGA, and the pending force survives the VGA cycle.
        next(); drive(1, 1'b0, 18'h00020, 16'h0); drive(2, 1'b0, 18'h00030, 16'h0);
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) next();
            samp();
        end
        next(); drive(0, 1'b0, 18'h00010, 16'h0); samp();
        chk("all3_vga_gnt", gnt, 3'b001);
        chk("all3_flag", uart_starved, 1'b1);
        next(); req[0] = 1'b0; samp();
        chk("all3_uart_gnt", gnt, 3'b100);
        drain(5);

        // Write to the top address, then read it straight back.
        next(); drive(1, 1'b1, 18'h3FFFF, 16'h1234); samp();
        chk("raw_wr_gnt", gnt, 3'b010);
        next(); drive(1, 1'b0, 18'h3FFFF, 16'h0); samp();
        chk("raw_rd_gnt", gnt, 3'b010);
        chk("raw_we_n_low", SRAM_we_n, 1'b0);
        chk("raw_wr_addr", SRAM_address, 18'h3FFFF);
        chk("raw_wr_data", SRAM_write_data, 16'h1234);
        next(); idle(); samp();
        chk("raw_we_n_high", SRAM_we_n, 1'b1);
        chk("raw_rd_addr", SRAM_address, 18'h3FFFF);
        next(); samp();
        chk("raw_no_wr_rvalid", rvalid, 3'b000);
        next(); samp();
        chk("raw_rvalid", rvalid, 3'b010);
        chk("raw_rdata", rdata, 16'h1234);
        drain(4);

        // Back-to-back V, D, U, V reads come back in order with no bubbles.
        iss_port = '{0, 1, 2, 0};
        iss_addr = '{18'h00010, 18'h00020, 18'h00030, 18'h00040};
        exp_rv   = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_rd   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 7; i++) begin
            next();
            idle();
            if (i < 4) drive(iss_port[i], 1'b0, iss_addr[i], 16'h0);
            samp();
            if (i < 4) chk($sformatf("mix_gnt[%0d]", i), gnt, exp_rv[i]);
            if (i >= 3) begin
                chk($sformatf("mix_rvalid[%0d]", i - 3), rvalid, exp_rv[i-3]);
                chk($sformatf("mix_rdata[%0d]", i - 3), rdata, exp_rd[i-3]);
            end
        end
        drain(3);

        // Reset pulse discards two in-flight reads.
        next(); drive(0, 1'b0, 18'h00010, 16'h0); samp();
        next(); idle(); drive(1, 1'b0, 18'h00020, 16'h0); samp();
        next(); idle(); Resetn = 1'b0; samp();
        chk("arst_we_n", SRAM_we_n, 1'b1);
        chk("arst_addr", SRAM_address, 18'h0);
        chk("arst_rvalid", rvalid, 3'b000);
        next(); Resetn = 1'b1; samp();
        chk("arst_rel_rvalid", rvalid, 3'b000);
        for (int i = 0; i < 4; i++) begin
            next(); samp();
            chk($sformatf("arst_post_rvalid[%0d]", i), rvalid, 3'b000);
            chk($sformatf("arst_post_we_n[%0d]", i), SRAM_we_n, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
